// File: rtl/id_pkg.sv
// Shared decode definitions for the instruction-decode stage: opcodes,
// immediate formats, per-opcode operand usage and default widths.
package id_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;
    localparam int unsigned NREG_DEFAULT = 32;
    localparam int unsigned INSTR_W      = 32;

    typedef enum logic [6:0] {
        OPC_OP     = 7'b0110011,
        OPC_OP_IMM = 7'b0010011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_BRANCH = 7'b1100011,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111
    } opcode_e;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_NONE
    } fmt_e;

    // Register usage and legality of one opcode.
    typedef struct packed {
        logic uses_rs1;
        logic uses_rs2;
        logic writes_rd;
        logic illegal;
    } op_class_t;

    // Immediate format selected by the opcode; unknown opcodes carry no immediate.
    function automatic fmt_e opcode_fmt(input logic [6:0] opc);
        fmt_e fmt;
        fmt = FMT_NONE;
        case (opc)
            OPC_OP:                         fmt = FMT_R;
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: fmt = FMT_I;
            OPC_STORE:                      fmt = FMT_S;
            OPC_BRANCH:                     fmt = FMT_B;
            OPC_LUI, OPC_AUIPC:             fmt = FMT_U;
            OPC_JAL:                        fmt = FMT_J;
            default:                        fmt = FMT_NONE;
        endcase
        return fmt;
    endfunction

    // Which architectural registers the opcode reads and writes.
    function automatic op_class_t opcode_class(input logic [6:0] opc);
        op_class_t c;
        c = '0;
        case (opc)
            OPC_OP: begin
                c.uses_rs1  = 1'b1;
                c.uses_rs2  = 1'b1;
                c.writes_rd = 1'b1;
            end
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
                c.uses_rs1  = 1'b1;
                c.writes_rd = 1'b1;
            end
            OPC_STORE, OPC_BRANCH: begin
                c.uses_rs1 = 1'b1;
                c.uses_rs2 = 1'b1;
            end
            OPC_JAL, OPC_LUI, OPC_AUIPC: begin
                c.writes_rd = 1'b1;
            end
            default: begin
                c.illegal = 1'b1;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: extracts the I/S/B/U/J immediate of an RV32I word and
// sign-extends it to XLen. R-type and illegal encodings give zero.
//   instr  : instruction word
//   imm_c  : sign-extended immediate (combinational)
module imm_gen
    import id_pkg::*;
#(
    parameter int unsigned XLen = XLEN_DEFAULT
) (
    input  logic [INSTR_W-1:0] instr,
    output logic [XLen-1:0]    imm_c
);

    fmt_e         fmt;
    logic [31:0]  imm32;

    assign fmt = opcode_fmt(instr[6:0]);

    // Bit scatter per format, built as a 32-bit value then widened.
    always_comb begin
        imm32 = '0;
        case (fmt)
            FMT_I: imm32 = {{20{instr[31]}}, instr[31:20]};
            FMT_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B: imm32 = {{19{instr[31]}}, instr[31], instr[7],
                            instr[30:25], instr[11:8], 1'b0};
            FMT_U: imm32 = {instr[31:12], 12'b0};
            FMT_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12],
                            instr[20], instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm_c = XLen'($signed(imm32));

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: decodes the fetched instruction, reads operands from
// the register file with writeback bypass, tracks in-flight destination
// registers in a scoreboard to stall on RAW hazards, and holds the decoded
// instruction in the ID/EX register under a valid/ready handshake.
//   clk_i, rst_ni                     : clock, async active-low reset
//   instr_valid_i/instr_ready_o       : fetch handshake, instr_i / pc_i payload
//   flush_i                           : squash the instruction held in ID/EX
//   rf_a1_o, rf_a2_o, rf_rd1_i/2_i    : register file read port
//   wb_we_i, wb_rd_i, wb_wd_i         : writeback port (bypass + scoreboard clear)
//   ex_valid_o/ex_ready_i             : execute handshake
//   ex_*                              : registered decoded instruction
module id_stage
    import id_pkg::*;
#(
    parameter  int unsigned XLen      = XLEN_DEFAULT,
    parameter  int unsigned NReg      = NREG_DEFAULT,
    localparam int unsigned NRegWidth = $clog2(NReg)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 instr_valid_i,
    output logic                 instr_ready_o,
    input  logic [INSTR_W-1:0]   instr_i,
    input  logic [XLen-1:0]      pc_i,
    input  logic                 flush_i,
    output logic [NRegWidth-1:0] rf_a1_o,
    output logic [NRegWidth-1:0] rf_a2_o,
    input  logic [XLen-1:0]      rf_rd1_i,
    input  logic [XLen-1:0]      rf_rd2_i,
    input  logic                 wb_we_i,
    input  logic [NRegWidth-1:0] wb_rd_i,
    input  logic [XLen-1:0]      wb_wd_i,
    output logic                 ex_valid_o,
    input  logic                 ex_ready_i,
    output logic [XLen-1:0]      ex_pc_o,
    output logic [XLen-1:0]      ex_op_a_o,
    output logic [XLen-1:0]      ex_op_b_o,
    output logic [XLen-1:0]      ex_imm_o,
    output logic [NRegWidth-1:0] ex_rd_o,
    output logic                 ex_rd_we_o,
    output logic [6:0]           ex_opcode_o,
    output logic [2:0]           ex_funct3_o,
    output logic [6:0]           ex_funct7_o,
    output logic                 ex_illegal_o
);

    logic [6:0]           opcode;
    logic [NRegWidth-1:0] rs1;
    logic [NRegWidth-1:0] rs2;
    logic [NRegWidth-1:0] rd;
    op_class_t            cls;
    logic                 rd_we;
    logic [XLen-1:0]      imm;

    logic                 wb_hit1;
    logic                 wb_hit2;
    logic                 hazard;
    logic                 accept;
    logic [XLen-1:0]      op_a;
    logic [XLen-1:0]      op_b;

    logic [NReg-1:0]      pending;
    logic [NReg-1:0]      pending_nxt;

    // Field extraction and classification.
    assign opcode = instr_i[6:0];
    assign rs1    = NRegWidth'(instr_i[19:15]);
    assign rs2    = NRegWidth'(instr_i[24:20]);
    assign rd     = NRegWidth'(instr_i[11:7]);
    assign cls    = opcode_class(opcode);
    assign rd_we  = cls.writes_rd && (rd != '0);

    assign rf_a1_o = rs1;
    assign rf_a2_o = rs2;

    imm_gen #(
        .XLen (XLen)
    ) u_imm_gen (
        .instr (instr_i),
        .imm_c (imm)
    );

    // A writeback landing this cycle resolves the hazard and supplies the operand.
    assign wb_hit1 = wb_we_i && (wb_rd_i == rs1);
    assign wb_hit2 = wb_we_i && (wb_rd_i == rs2);

    assign hazard = (cls.uses_rs1 && pending[rs1] && !wb_hit1)
                 || (cls.uses_rs2 && pending[rs2] && !wb_hit2);

    assign instr_ready_o = (!ex_valid_o || ex_ready_i) && !hazard && !flush_i;
    assign accept        = instr_valid_i && instr_ready_o;

    // Operand select: x0 reads as zero regardless of register file contents.
    assign op_a = (rs1 == '0) ? '0 : (wb_hit1 ? wb_wd_i : rf_rd1_i);
    assign op_b = (rs2 == '0) ? '0 : (wb_hit2 ? wb_wd_i : rf_rd2_i);

    // Scoreboard update; ordering makes a new reservation win over a same-cycle clear.
    always_comb begin
        pending_nxt = pending;
        if (flush_i && ex_valid_o && ex_rd_we_o) begin
            pending_nxt[ex_rd_o] = 1'b0;
        end
        if (wb_we_i) begin
            pending_nxt[wb_rd_i] = 1'b0;
        end
        if (accept && rd_we) begin
            pending_nxt[rd] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    // ID/EX register: payload only changes on accept, so it holds under backpressure.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ex_valid_o   <= 1'b0;
            ex_pc_o      <= '0;
            ex_op_a_o    <= '0;
            ex_op_b_o    <= '0;
            ex_imm_o     <= '0;
            ex_rd_o      <= '0;
            ex_rd_we_o   <= 1'b0;
            ex_opcode_o  <= '0;
            ex_funct3_o  <= '0;
            ex_funct7_o  <= '0;
            ex_illegal_o <= 1'b0;
        end else if (accept) begin
            ex_valid_o   <= 1'b1;
            ex_pc_o      <= pc_i;
            ex_op_a_o    <= op_a;
            ex_op_b_o    <= op_b;
            ex_imm_o     <= imm;
            ex_rd_o      <= rd;
            ex_rd_we_o   <= rd_we;
            ex_opcode_o  <= opcode;
            ex_funct3_o  <= instr_i[14:12];
            ex_funct7_o  <= instr_i[31:25];
            ex_illegal_o <= cls.illegal;
        end else if (flush_i || ex_ready_i) begin
            ex_valid_o   <= 1'b0;
        end
    end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 Parameter XLen, default 32: datapath width in bits.
REQ-002 Parameter NReg, default 32: architectural register count; NRegWidth = $clog2(NReg).
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 instr_valid_i  input  1  upstream (fetch) instruction valid.
REQ-006 instr_ready_o  output  1  stage accepts instr_i this cycle.
REQ-007 instr_i  input  32  RV32I instruction word; pc_i  input  XLen  its PC.
REQ-008 flush_i  input  1  squash the instruction held in the ID/EX register.
REQ-009 rf_a1_o, rf_a2_o  output  NRegWidth  register file read addresses (rs1, rs2), combinational from instr_i.
REQ-010 rf_rd1_i, rf_rd2_i  input  XLen  register file asynchronous read data.
REQ-011 wb_we_i  input  1; wb_rd_i  input  NRegWidth; wb_wd_i  input  XLen  writeback port (same values drive the register file write port).
REQ-012 ex_valid_o  output  1; ex_ready_i  input  1  downstream (execute) handshake.
REQ-013 ex_pc_o, ex_op_a_o, ex_op_b_o, ex_imm_o  output  XLen  registered PC, rs1 value, rs2 value, sign-extended immediate.
REQ-014 ex_rd_o  output  NRegWidth; ex_rd_we_o  output  1; ex_opcode_o  output  7; ex_funct3_o  output  3; ex_funct7_o  output  7; ex_illegal_o  output  1.

Function
REQ-015 Decode SHALL classify opcode: R 0110011, OP-IMM 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111; any other opcode is illegal.
REQ-016 uses_rs1 for R, OP-IMM, LOAD, STORE, BRANCH, JALR; uses_rs2 for R, STORE, BRANCH; rd_we for R, OP-IMM, LOAD, JAL, JALR, LUI, AUIPC and only when rd != 0.
REQ-017 Immediates sign-extended to XLen per I, S, B, U, J formats; R-type and illegal imm = 0.
REQ-018 Illegal instruction: ex_illegal_o=1, ex_rd_we_o=0, uses no source registers.
REQ-019 Scoreboard: NReg-bit pending mask; bit 0 never set.
REQ-020 hazard = (uses_rs1 and pending[rs1] and not(wb_we_i and wb_rd_i==rs1)) or same for rs2.
REQ-021 instr_ready_o = (!ex_valid_o or ex_ready_i) and !hazard and !flush_i.
REQ-022 Accept = instr_valid_i and instr_ready_o; on accept the ID/EX register loads all ex_* fields next edge and ex_valid_o=1.
REQ-023 Operand bypass: if wb_we_i, wb_rd_i==rsN and rsN!=0, operand N = wb_wd_i, else rf_rdN_i; rs=0 always yields 0.
REQ-024 Scoreboard set pending[rd] on accept with rd_we; clear pending[wb_rd_i] on wb_we_i; simultaneous set and clear of same index: set wins.
REQ-025 ex_valid_o drops to 0 when ex_ready_i=1 and no accept; with ex_ready_i=0 all ex_* outputs hold stable.
REQ-026 flush_i: next edge ex_valid_o=0 and, if the held instruction has ex_rd_we_o=1, its pending bit is cleared (writeback clears to other indices still apply).
REQ-027 Latency: accept to ex_valid_o exactly 1 cycle; throughput 1 instruction/cycle absent hazards.

Reset
REQ-028 While rst_ni=0: ex_valid_o=0, all ex_* data outputs 0, scoreboard all 0; instr_ready_o then depends only on flush_i.
REQ-029 Reset asserted mid-operation discards the held instruction and all pending bits immediately, without a clock edge.

Structure
REQ-030 Shared package id_pkg: opcode enum, instruction-format enum, XLen/NReg defaults.
REQ-031 One sub-module imm_gen (combinational, instr_i -> immediate); scoreboard and ID/EX register inline.

Verification
REQ-032 addi x1,x0,5 (0x00500093) accepted -> next cycle ex_valid_o=1, ex_rd_o=1, ex_imm_o=5, ex_rd_we_o=1, pending[1]=1.
REQ-033 Then add x2,x1,x1 (0x00108133) -> instr_ready_o=0; on cycle with wb_we_i=1, wb_rd_i=1, wb_wd_i=5 -> accepted, ex_op_a_o=ex_op_b_o=5.
REQ-034 ex_ready_i=0 for 3 cycles with ex_valid_o=1 -> ex_* unchanged, instr_ready_o=0; ex_ready_i=1 -> new accept.
REQ-035 addi x0,x0,1 (0x00100013) then add x3,x0,x0 -> no stall, ex_rd_we_o=0 for first, operands 0 for second.
REQ-036 Held lui x3,0x12345 (0x123451B7) with flush_i=1 -> next cycle ex_valid_o=0, pending[3]=0.
REQ-037 rst_ni=0 while pending[1]=1 and ex_valid_o=1 -> both 0 immediately; opcode 0x7F after reset -> ex_illegal_o=1.
